serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter. It is the sending end of the lab's serial link: it drives the line that the receiver-side flop chain samples.
- Accepts one WIDTH-bit word per handshake and sends it in this order: start bit, data bits LSB first, optional even-parity bit, stop bit.
- Each bit is held for DIV clocks.
- Drives a true line output and a complementary line output, matching the lab's q/qb output pair style.

Parameters:
- WIDTH, 8, data bits per frame (1..16)
- DIV, 4, clk cycles per serial bit (>=1)
- PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
- clk  input  1  clock; all state updates on the falling edge
- rst  input  1  asynchronous, active-low reset
- load  input  1  request to send din; honoured only while ready=1
- din  input  WIDTH  word to transmit; sampled on the accepting edge
- ready  output  1  1 = idle and able to accept load
- busy  output  1  1 = frame in progress (always ~ready)
- done  output  1  one-cycle pulse when the stop bit completes
- sout  output  1  serial line; idles high
- soutb  output  1  always ~sout

Behaviour:
- Clocking: all registers update on the negedge of clk. rst low asynchronously forces the reset state, regardless of clk.
- Reset values: sout=1, soutb=0, ready=1, busy=0, done=0, state=IDLE, bit timer=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - sout=1.
  - On a falling edge with load=1: latch din into the shift register, compute parity = XOR of din, clear the timer, go to START.
  - On that same edge: ready->0, busy->1, sout->0.
- Bit timer: counts 0..DIV-1. The last count (DIV-1) is the bit-end edge. On a bit-end edge the timer returns to 0 and the FSM advances; otherwise the state holds.
- START: sout=0 for DIV cycles. At bit-end: go to DATA, bit index=0.
- DATA: sout = shift register bit 0. At bit-end: shift right by 1 and increment the index.
  - If index==WIDTH-1, go to PARITY when PARITY_EN=1, else go to STOP.
- PARITY: sout = latched parity for DIV cycles. At bit-end: go to STOP.
- STOP: sout=1 for DIV cycles. At bit-end:
  - go to IDLE;
  - ready->1, busy->0;
  - done=1 for exactly that one cycle.
- Latency: acceptance edge to done edge = (WIDTH + PARITY_EN + 2) * DIV falling edges.
- load while busy: ignored. din is not re-sampled mid-frame, and a held load does not queue.
- load high on the done edge: not accepted on that edge, because ready is still 0 when sampled. It is accepted on the next falling edge if still high, so the minimum idle gap between frames is 1 cycle.
- load held high continuously: back-to-back frames separated by exactly 1 idle-high cycle.
- DIV=1: every edge is a bit-end edge. The timer is degenerate (width 1, constant 0).
- Reset mid-frame: the line returns high immediately. The frame is aborted with no done pulse, and no partial bits resume after reset is released.
- sout and soutb come directly from registers, with no combinational path from load or din.

Decomposition:
- Package serial_link_pkg holds:
  - the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits);
  - LINE_IDLE=1 and START_LEVEL=0;
  - a function clog2 for sizing the timer and index.
- One sub-module, bit_timer:
  - negedge counter 0..DIV-1 with clear input, async active-low rst, and a tick output asserted on the bit-end count.
  - The FSM, shift register and parity live in serial_frame_tx.

Test Plan:
- Reset: hold rst=0 for 3 cycles with load=1 -> sout=1, soutb=0, ready=1, busy=0, done=0 throughout. No frame starts until rst=1 and a falling edge occurs.
- Basic frame (WIDTH=8, DIV=4, PARITY_EN=1, din=8'hA5, one-cycle load pulse) -> sout sequence 0 | 1,0,1,0,0,1,0,1 | 0 | 1. Each value holds 4 cycles. done pulses on falling edge 44 after acceptance, and ready rises on that same edge.
- Busy rejection: while the 8'hA5 frame is in DATA, pulse load with din=8'h3C -> the transmitted bits are unchanged, only one done pulse occurs, and no second frame follows.
- Back-to-back: hold load=1 with din=8'hFF then 8'h00, PARITY_EN=0, DIV=1 -> the first frame is 0,1x8,1 and done fires at edge 10. There is exactly 1 idle cycle, then the second frame is 0,0x8,1.
- Mid-frame reset: start 8'h81 with DIV=4, then assert rst low during data bit 3 -> sout goes to 1 asynchronously (before the next edge) and no done pulse occurs. After release a new load of 8'h01 transmits a clean full frame.
- Parity check: din=8'h07 with PARITY_EN=1 -> parity bit=1. din=8'h03 -> parity bit=0. soutb equals ~sout on every sampled cycle.

Source files
------------

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared state encoding, line levels and sizing helper for the serial link
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Bits needed to hold 0..value-1; never below 1 so degenerate counters stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// rtl/serial_frame_tx_bit_timer.sv - negedge bit-period counter with clear and bit-end tick
module bit_timer
  import serial_link_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = clog2(DIV);

  logic [CW-1:0] count;

  // With DIV=1 the count is pinned at 0, so every edge is a bit-end edge.
  assign tick = (count == CW'(DIV - 1));

  // Count 0..DIV-1, wrapping on the bit-end edge or when the frame logic clears it.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-in serial-out frame transmitter with optional even parity
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             sout,
  output logic             soutb
);

  localparam int IW = clog2(WIDTH);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_d;
  logic [IW-1:0]    index;
  logic [IW-1:0]    index_d;
  logic             parity;
  logic             parity_d;
  logic             sout_d;
  logic             ready_d;
  logic             done_d;
  logic             tick;
  logic             timer_clear;

  // Holding the timer cleared while idle makes the accepting edge start a fresh bit period.
  assign timer_clear = (state == IDLE);

  bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // State register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, datapath updates and the line level for the state being entered.
  always_comb begin
    state_d  = state;
    shift_d  = shift;
    index_d  = index;
    parity_d = parity;
    done_d   = 1'b0;
    sout_d   = LINE_IDLE;
    unique case (state)
      IDLE: begin
        if (load) begin
          shift_d  = din;
          parity_d = ^din;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          index_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift >> 1;
          index_d = index + IW'(1);
          if (index == IW'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   sout_d = START_LEVEL;
      DATA:    sout_d = shift_d[0];
      PARITY:  sout_d = parity_d;
      default: sout_d = LINE_IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Registered datapath and outputs so the line never sees a combinational path from load/din.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      shift  <= '0;
      index  <= '0;
      parity <= 1'b0;
      sout   <= LINE_IDLE;
      soutb  <= ~LINE_IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      shift  <= shift_d;
      index  <= index_d;
      parity <= parity_d;
      sout   <= sout_d;
      soutb  <= ~sout_d;
      ready  <= ready_d;
      busy   <= ~ready_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx against a frame-level model
module tb_serial_frame_tx;

  localparam int W     = 8;
  localparam int DIV_A = 4;
  localparam int PAR_A = 1;
  localparam int DIV_B = 1;
  localparam int PAR_B = 0;

  logic       clk = 1'b1;
  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic       ready_a, busy_a, done_a, sout_a, soutb_a;
  logic       ready_b, busy_b, done_b, sout_b, soutb_b;

  serial_frame_tx #(.WIDTH(W), .DIV(DIV_A), .PARITY_EN(PAR_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .load(load_a), .din(din_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .sout(sout_a), .soutb(soutb_a)
  );

  serial_frame_tx #(.WIDTH(W), .DIV(DIV_B), .PARITY_EN(PAR_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .load(load_b), .din(din_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .sout(sout_b), .soutb(soutb_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // k-th bit of a frame: start, data LSB first, optional even parity, stop.
  function automatic bit frame_bit(input logic [7:0] d, input int par_en, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return d[k-1];
    if (par_en != 0 && k == W + 1) return ^d;
    return 1'b1;
  endfunction

  // Model A: queue of line levels, one per falling edge of the frame.
  bit qa[$];
  bit ma_busy = 0, ea_sout = 1, ea_ready = 1, ea_done = 0;
  always @(negedge clk or negedge rst_a) begin
    if (!rst_a) begin
      qa.delete(); ma_busy = 0; ea_sout = 1; ea_ready = 1; ea_done = 0;
    end else if (!ma_busy) begin
      ea_done = 0;
      if (load_a) begin
        for (int k = 0; k < W + PAR_A + 2; k++)
          for (int d = 0; d < DIV_A; d++) qa.push_back(frame_bit(din_a, PAR_A, k));
        ma_busy = 1; ea_sout = qa.pop_front(); ea_ready = 0;
      end else begin
        ea_sout = 1; ea_ready = 1;
      end
    end else if (qa.size() > 0) begin
      ea_sout = qa.pop_front(); ea_done = 0; ea_ready = 0;
    end else begin
      ma_busy = 0; ea_done = 1; ea_sout = 1; ea_ready = 1;
    end
  end

  // Model B: same rules, second parameter set.
  bit qb[$];
  bit mb_busy = 0, eb_sout = 1, eb_ready = 1, eb_done = 0;
  always @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      qb.delete(); mb_busy = 0; eb_sout = 1; eb_ready = 1; eb_done = 0;
    end else if (!mb_busy) begin
      eb_done = 0;
      if (load_b) begin
        for (int k = 0; k < W + PAR_B + 2; k++)
          for (int d = 0; d < DIV_B; d++) qb.push_back(frame_bit(din_b, PAR_B, k));
        mb_busy = 1; eb_sout = qb.pop_front(); eb_ready = 0;
      end else begin
        eb_sout = 1; eb_ready = 1;
      end
    end else if (qb.size() > 0) begin
      eb_sout = qb.pop_front(); eb_done = 0; eb_ready = 0;
    end else begin
      mb_busy = 0; eb_done = 1; eb_sout = 1; eb_ready = 1;
    end
  end

  always @(negedge clk) edge_n <= edge_n + 1;

  bit   log_a[$], log_b[$];
  int   acc_a = -1, done_edge_a = -1, done_cnt_a = 0;
  int   acc_b_q[$], done_b_q[$];
  logic ready_a_prev = 1'b1, ready_b_prev = 1'b1;

  // Per-cycle comparison against the models, plus edge bookkeeping for the literal checks.
  always @(posedge clk) begin
    check("a_sout", sout_a, ea_sout);
    check("a_soutb", soutb_a, !ea_sout);
    check("a_ready", ready_a, ea_ready);
    check("a_busy", busy_a, !ea_ready);
    check("a_done", done_a, ea_done);
    check("b_sout", sout_b, eb_sout);
    check("b_soutb", soutb_b, !eb_sout);
    check("b_ready", ready_b, eb_ready);
    check("b_busy", busy_b, !eb_ready);
    check("b_done", done_b, eb_done);
    if (busy_a === 1'b1) log_a.push_back(sout_a);
    if (busy_b === 1'b1) log_b.push_back(sout_b);
    if (ready_a_prev === 1'b1 && ready_a === 1'b0) acc_a = edge_n;
    if (done_a === 1'b1) begin done_edge_a = edge_n; done_cnt_a++; end
    if (ready_b_prev === 1'b1 && ready_b === 1'b0) acc_b_q.push_back(edge_n);
    if (done_b === 1'b1) done_b_q.push_back(edge_n);
    ready_a_prev = ready_a;
    ready_b_prev = ready_b;
  end

  task automatic wait_done(input int which, input int budget);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      seen = (which == 0) ? done_a : done_b;
      n++;
    end
    check((which == 0) ? "a_done_wait" : "b_done_wait", seen, 1);
  endtask

  task automatic wait_accept(input int which, input int budget);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      seen = (which == 0) ? !ready_a : !ready_b;
      n++;
    end
    check((which == 0) ? "a_accept_wait" : "b_accept_wait", seen, 1);
  endtask

  task automatic run_frame_a(input logic [7:0] d);
    log_a.delete();
    @(posedge clk); #2 din_a = d; load_a = 1;
    @(posedge clk); #2 load_a = 0;
    wait_done(0, 80);
    repeat (2) @(posedge clk);
  endtask

  bit a5_exp[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  int cnt0;

  initial begin
    // Reset held with load asserted: nothing may start.
    load_a = 1; load_b = 1; din_a = 8'h5A; din_b = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sout_a", sout_a, 1);
    check("rst_ready_b", ready_b, 1);
    #1 rst_a = 1; rst_b = 1; load_a = 0; load_b = 0;
    repeat (3) @(posedge clk);
    #1 check("idle_busy_a", busy_a, 0);

    // Basic A5 frame with a rejected load during DATA.
    log_a.delete(); cnt0 = done_cnt_a;
    @(posedge clk); #2 din_a = 8'hA5; load_a = 1;
    @(posedge clk); #2 load_a = 0;
    repeat (14) @(posedge clk);
    #2 din_a = 8'h3C; load_a = 1;
    @(posedge clk); #2 load_a = 0; din_a = 8'h00;
    wait_done(0, 60);
    repeat (20) @(posedge clk);
    #1;
    check("a5_latency", done_edge_a - acc_a, 44);
    check("a5_done_count", done_cnt_a - cnt0, 1);
    check("a5_len", log_a.size(), 44);
    for (int i = 0; i < 11; i++) check($sformatf("a5_bit%0d", i), log_a[4*i], a5_exp[i]);

    // Parity bit values.
    run_frame_a(8'h07);
    check("par_07", log_a[36], 1);
    run_frame_a(8'h03);
    check("par_03", log_a[36], 0);

    // Mid-frame reset during data bit 3 of 8'h81.
    cnt0 = done_cnt_a;
    @(posedge clk); #2 din_a = 8'h81; load_a = 1;
    @(posedge clk); #2 load_a = 0;
    repeat (17) @(posedge clk);
    #2 check("mid_bit3_level", sout_a, 0);
    rst_a = 0;
    #1;
    check("mid_rst_sout", sout_a, 1);
    check("mid_rst_soutb", soutb_a, 0);
    check("mid_rst_ready", ready_a, 1);
    repeat (2) @(posedge clk);
    #2 rst_a = 1;
    repeat (50) @(posedge clk);
    check("mid_no_done", done_cnt_a - cnt0, 0);
    run_frame_a(8'h01);
    check("after_rst_len", log_a.size(), 44);
    check("after_rst_done", done_cnt_a - cnt0, 1);
    check("after_rst_bit0", log_a[4], 1);
    check("after_rst_bit1", log_a[8], 0);

    // Back-to-back on DIV=1, no parity.
    acc_b_q.delete(); done_b_q.delete();
    @(posedge clk); #2 din_b = 8'hFF; load_b = 1;
    wait_accept(1, 10);
    #1 din_b = 8'h00;
    wait_done(1, 30);
    log_b.delete();
    wait_accept(1, 10);
    #1 load_b = 0;
    wait_done(1, 30);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_accepts", acc_b_q.size(), 2);
    check("b2b_latency", done_b_q[0] - acc_b_q[0], 10);
    check("b2b_gap", acc_b_q[1] - done_b_q[0], 1);
    check("b2b_len", log_b.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("b2b_bit%0d", i), log_b[i], (i == 9) ? 1 : 0);

    // Randomized traffic with occasional resets, checked by the models every cycle.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #2;
      load_a = ($urandom_range(0, 15) == 0);
      din_a  = 8'($urandom);
      load_b = ($urandom_range(0, 1) == 1);
      din_b  = 8'($urandom);
      rst_a  = ($urandom_range(0, 499) != 0);
      rst_b  = ($urandom_range(0, 499) != 0);
    end
    @(posedge clk); #2 load_a = 0; load_b = 0; rst_a = 1; rst_b = 1;
    repeat (60) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
